// File: rtl/tank_ctrl_if.sv
// Player-tank signal bundle: keyboard/map/opponent inputs and tank position/event outputs.
interface tank_ctrl_if;
    logic [7:0] keycode;
    logic [3:0] map_tile;
    logic [4:0] other_tx;
    logic [4:0] other_ty;
    logic [8:0] map_addr;
    logic [9:0] TankX;
    logic [9:0] TankY;
    logic [4:0] tile_x;
    logic [4:0] tile_y;
    logic [1:0] dir;
    logic       moved;
    logic       blocked;
    logic       fire;

    modport master (
        input  keycode, map_tile, other_tx, other_ty,
        output map_addr, TankX, TankY, tile_x, tile_y, dir, moved, blocked, fire
    );

    modport slave (
        output keycode, map_tile, other_tx, other_ty,
        input  map_addr, TankX, TankY, tile_x, tile_y, dir, moved, blocked, fire
    );
endinterface

// File: rtl/tank_ctrl.sv
// Tile-stepped tank controller: key-driven moves checked against map and opponent,
// with independent fire cooldown.
module tank_ctrl #(
    parameter int         TILE_SHIFT  = 5,
    parameter int         MAP_W       = 20,
    parameter int         MAP_H       = 15,
    parameter int         START_TX    = 1,
    parameter int         START_TY    = 13,
    parameter int         START_DIR   = 0,
    parameter int         MOVE_PERIOD = 8,
    parameter int         FIRE_PERIOD = 30,
    parameter logic [7:0] KEY_UP      = 8'h1A,
    parameter logic [7:0] KEY_DOWN    = 8'h16,
    parameter logic [7:0] KEY_LEFT    = 8'h04,
    parameter logic [7:0] KEY_RIGHT   = 8'h07,
    parameter logic [7:0] KEY_FIRE    = 8'h2C
) (
    input  logic         frame_clk,
    input  logic         Reset,
    tank_ctrl_if.master  bus
);

    localparam int MCW = $clog2(MOVE_PERIOD + 1);
    localparam int FCW = $clog2(FIRE_PERIOD + 1);

    typedef enum logic [1:0] {IDLE, WAIT, CHECK} state_e;

    state_e         state_q, state_d;
    logic [4:0]     tx_q, tx_d, ty_q, ty_d;
    logic [4:0]     tgt_x_q, tgt_x_d, tgt_y_q, tgt_y_d;
    logic [1:0]     dir_q, dir_d;
    logic [MCW-1:0] mcool_q, mcool_d;
    logic [FCW-1:0] fcool_q, fcool_d;
    logic [8:0]     addr_q, addr_d;
    logic           moved_q, moved_d, blocked_q, blocked_d, fire_q, fire_d;

    logic           is_dir;
    logic [1:0]     kdir;
    logic [5:0]     nx, ny;
    logic           oob, hit;

    always_comb begin
        is_dir = 1'b1;
        kdir   = 2'd0;
        if      (bus.keycode == KEY_UP)    kdir = 2'd0;
        else if (bus.keycode == KEY_DOWN)  kdir = 2'd1;
        else if (bus.keycode == KEY_LEFT)  kdir = 2'd2;
        else if (bus.keycode == KEY_RIGHT) kdir = 2'd3;
        else                               is_dir = 1'b0;
    end

    // Stepping left/up off tile 0 wraps to 6'h3F, which the unsigned bound check rejects.
    always_comb begin
        nx = {1'b0, tx_q};
        ny = {1'b0, ty_q};
        case (kdir)
            2'd0:    ny = ny - 6'd1;
            2'd1:    ny = ny + 6'd1;
            2'd2:    nx = nx - 6'd1;
            default: nx = nx + 6'd1;
        endcase
        oob = (nx >= 6'(MAP_W)) || (ny >= 6'(MAP_H));
        hit = (nx == {1'b0, bus.other_tx}) && (ny == {1'b0, bus.other_ty});
    end

    always_comb begin
        state_d   = state_q;
        tx_d      = tx_q;
        ty_d      = ty_q;
        tgt_x_d   = tgt_x_q;
        tgt_y_d   = tgt_y_q;
        dir_d     = dir_q;
        mcool_d   = mcool_q;
        addr_d    = addr_q;
        moved_d   = 1'b0;
        blocked_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (mcool_q != '0) begin
                    mcool_d = mcool_q - 1'b1;
                end else if (is_dir) begin
                    dir_d = kdir;
                    if (oob || hit) begin
                        blocked_d = 1'b1;
                        mcool_d   = MCW'(MOVE_PERIOD);
                    end else begin
                        tgt_x_d = nx[4:0];
                        tgt_y_d = ny[4:0];
                        addr_d  = 9'(ny) * 9'(MAP_W) + 9'(nx);
                        state_d = WAIT;
                    end
                end
            end
            WAIT: state_d = CHECK;
            CHECK: begin
                if (bus.map_tile == 4'd0) begin
                    tx_d    = tgt_x_q;
                    ty_d    = tgt_y_q;
                    moved_d = 1'b1;
                end else begin
                    blocked_d = 1'b1;
                end
                mcool_d = MCW'(MOVE_PERIOD);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Fire runs regardless of the move FSM state.
    always_comb begin
        fire_d  = 1'b0;
        fcool_d = fcool_q;
        if (bus.keycode == KEY_FIRE && fcool_q == '0) begin
            fire_d  = 1'b1;
            fcool_d = FCW'(FIRE_PERIOD);
        end else if (fcool_q != '0) begin
            fcool_d = fcool_q - 1'b1;
        end
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state_q   <= IDLE;
            tx_q      <= 5'(START_TX);
            ty_q      <= 5'(START_TY);
            tgt_x_q   <= 5'(START_TX);
            tgt_y_q   <= 5'(START_TY);
            dir_q     <= 2'(START_DIR);
            mcool_q   <= '0;
            fcool_q   <= '0;
            addr_q    <= '0;
            moved_q   <= 1'b0;
            blocked_q <= 1'b0;
            fire_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_q      <= tx_d;
            ty_q      <= ty_d;
            tgt_x_q   <= tgt_x_d;
            tgt_y_q   <= tgt_y_d;
            dir_q     <= dir_d;
            mcool_q   <= mcool_d;
            fcool_q   <= fcool_d;
            addr_q    <= addr_d;
            moved_q   <= moved_d;
            blocked_q <= blocked_d;
            fire_q    <= fire_d;
        end
    end

    assign bus.map_addr = addr_q;
    assign bus.tile_x   = tx_q;
    assign bus.tile_y   = ty_q;
    assign bus.TankX    = {5'd0, tx_q} << TILE_SHIFT;
    assign bus.TankY    = {5'd0, ty_q} << TILE_SHIFT;
    assign bus.dir      = dir_q;
    assign bus.moved    = moved_q;
    assign bus.blocked  = blocked_q;
    assign bus.fire     = fire_q;

endmodule
